// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer:
//   PC_W     - width of the program counter (8 bits)
//   state_t  - sequencer FSM encoding, visible on the State port
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int PC_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// -----------------------------------------------------------------------------
// ret_stack
// LIFO return-address stack for the PC sequencer.
// Ports:
//   clk   - clock, rising-edge updates
//   rst_n - asynchronous active-low reset (empties the stack)
//   push  - write din on top (ignored when full)
//   pop   - remove top entry (ignored when empty)
//   din   - value to push
//   dout  - current top-of-stack value (zero when empty)
//   full  - DEPTH entries held
//   empty - no entries held
// push has priority if both are asserted in the same cycle.
// -----------------------------------------------------------------------------
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = AW'(count - CW'(1));
    assign wr_idx  = AW'(count);
    assign dout    = empty ? '0 : mem[top_idx];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the count alone
    // defines which entries are valid, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Four-state (IDLE/FETCH/EXEC/HALT) sequencer that computes the next value of
// an external 8-bit PC register. Outputs decode combinationally from the
// current state and inputs, so the PC loads on the edge that ends EXEC.
//
// Build option: define RET_STACK_EN to add a STACK_DEPTH x 8 return stack
// (Call pushes PCOut+1, Ret pops). Without it, Call acts as Jump, Ret is
// ignored and StackErr is tied low.
//
// Parameters:
//   RESET_VECTOR - PC value driven while in IDLE
//   STACK_DEPTH  - return-stack entries (RET_STACK_EN only)
// Ports:
//   Clock    in   clock, rising edge
//   Reset    in   asynchronous active-low reset
//   PCOut    in   [7:0] current PC register value
//   Start    in   leave IDLE or HALT
//   Stall    in   freeze sequencing this cycle
//   Branch, Taken, Jump, Call, Ret, Halt  in  EXEC-cycle control requests
//   Target   in   [7:0] branch/jump/call destination
//   PCIn     out  [7:0] next PC value
//   PCWrite  out  PC load enable
//   Fetch    out  instruction-fetch strobe
//   State    out  [1:0] current FSM state
//   StackErr out  sticky stack overflow/underflow flag
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 8'h00,
    parameter int              STACK_DEPTH  = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [PC_W-1:0] PCOut,
    input  logic            Start,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            Taken,
    input  logic            Jump,
    input  logic            Call,
    input  logic            Ret,
    input  logic            Halt,
    input  logic [PC_W-1:0] Target,
    output logic [PC_W-1:0] PCIn,
    output logic            PCWrite,
    output logic            Fetch,
    output logic [1:0]      State,
    output logic            StackErr
);

    state_t          state;
    state_t          next_state;
    logic [PC_W-1:0] pc_seq;

    // Wraps naturally at 8 bits: 8'hFF + 1 = 8'h00.
    assign pc_seq = PCOut + PC_W'(1);
    assign State  = state;

`ifdef RET_STACK_EN
    logic            stk_push;
    logic            stk_pop;
    logic            stk_full;
    logic            stk_empty;
    logic [PC_W-1:0] stk_top;
    logic            err_set;
    logic            stack_err;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk   (Clock),
        .rst_n (Reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_seq),
        .dout  (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign StackErr = stack_err;
`else
    logic unused_ok;
    assign unused_ok = ^{Ret, (STACK_DEPTH > 0)};
    assign StackErr  = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        PCIn       = PCOut;
        PCWrite    = 1'b0;
        Fetch      = 1'b0;
`ifdef RET_STACK_EN
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        err_set    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                PCIn    = RESET_VECTOR;
                PCWrite = 1'b1;
                if (Start) next_state = FETCH;
            end
            FETCH: begin
                Fetch = 1'b1;
                if (!Stall) next_state = EXEC;
            end
            EXEC: begin
                // Stall freezes the cycle entirely; otherwise Halt wins over
                // every other request and suppresses the PC write.
                if (!Stall) begin
                    if (Halt) begin
                        next_state = HALT;
                    end else begin
                        next_state = FETCH;
                        PCWrite    = 1'b1;
`ifdef RET_STACK_EN
                        if (Ret) begin
                            if (stk_empty) begin
                                PCIn    = pc_seq;
                                err_set = 1'b1;
                            end else begin
                                PCIn    = stk_top;
                                stk_pop = 1'b1;
                            end
                        end else if (Call) begin
                            PCIn = Target;
                            if (stk_full) err_set  = 1'b1;
                            else          stk_push = 1'b1;
                        end else if (Jump || (Branch && Taken)) begin
                            PCIn = Target;
                        end else begin
                            PCIn = pc_seq;
                        end
`else
                        if (Call || Jump || (Branch && Taken)) PCIn = Target;
                        else                                   PCIn = pc_seq;
`endif
                    end
                end
            end
            HALT: begin
                if (Start) next_state = FETCH;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
`ifdef RET_STACK_EN
            stack_err <= 1'b0;
`endif
        end else begin
            state     <= next_state;
`ifdef RET_STACK_EN
            if (err_set) stack_err <= 1'b1;
`endif
        end
    end

endmodule
